// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads a combinational ROM and
// queues {instruction, PC} pairs in a small prefetch FIFO drained by decode.
module fetch_ctrl #(
    parameter int                 tamanho      = 32,
    parameter int                 profundidade = 4,
    parameter logic [tamanho-1:0] pc_inicial   = '0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    output logic [tamanho-1:0]                mem_addr,
    input  logic [tamanho-1:0]                mem_data,
    output logic [tamanho-1:0]                instr,
    output logic [tamanho-1:0]                instr_pc,
    output logic                              instr_valid,
    input  logic                              instr_ready,
    input  logic                              redirect,
    input  logic [tamanho-1:0]                redirect_pc,
    input  logic                              halt,
    output logic [$clog2(profundidade):0]     count
);

    localparam int pw = $clog2(profundidade);
    localparam int cw = pw + 1;

    logic [tamanho-1:0] fetch_pc;
    logic [pw-1:0]      wr_ptr;
    logic [pw-1:0]      rd_ptr;
    logic               push;
    logic               pop;
    logic               unused_bits;

    logic [tamanho-1:0] instr_mem [profundidade];
    logic [tamanho-1:0] pc_mem    [profundidade];

    // The low two target bits are dropped because fetch is word aligned.
    assign unused_bits = ^redirect_pc[1:0];

    assign mem_addr    = fetch_pc;
    assign instr_valid = (count != '0);

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        pop  = instr_valid & instr_ready & ~redirect;
        push = ~redirect & ~halt & ((count < cw'(profundidade)) | pop);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= pc_inicial;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[tamanho-1:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + pw'(1);
                fetch_pc <= fetch_pc + tamanho'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + pw'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + cw'(1);
                2'b01:   count <= count - cw'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is not reset; stale slots are never visible because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= mem_data;
            pc_mem[wr_ptr]    <= fetch_pc;
        end
    end

    assign instr    = instr_valid ? instr_mem[rd_ptr] : '0;
    assign instr_pc = instr_valid ? pc_mem[rd_ptr]    : '0;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer sitting between the PC logic and the instruction memory (word-addressed ROM, combinational read). It owns the fetch PC, drives the memory address every cycle and captures {instruction, PC} pairs into a small prefetch FIFO. Decode consumes the FIFO through a valid/ready handshake. Branch/jump redirects flush the FIFO and restart fetch at the target.

Parameters:
tamanho, 32, data/address width in bits
profundidade, 4, prefetch FIFO depth in entries (power of 2, ≥2)
pc_inicial, 0, fetch PC value after reset (word aligned)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_addr  out  tamanho  byte address to instruction memory (= fetch_pc)
mem_data  in  tamanho  instruction word returned combinationally for mem_addr
instr  out  tamanho  instruction at FIFO head
instr_pc  out  tamanho  byte PC of instr
instr_valid  out  1  FIFO head holds a valid entry
instr_ready  in  1  consumer accepts head this cycle
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  tamanho  redirect target (bits [1:0] ignored)
halt  in  1  stop issuing new fetches; FIFO keeps draining
count  out  clog2(profundidade)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, async): fetch_pc=pc_inicial, count=0, rd/wr pointers=0, instr_valid=0; instr/instr_pc = 0. Remains so until first rising edge with rst_n high.
- mem_addr = fetch_pc, purely combinational from the register; mem_data sampled at same edge.
- pop = instr_valid & instr_ready & ~redirect.
- push = ~redirect & ~halt & (count < profundidade | pop). Full FIFO with simultaneous pop: push and pop both occur, count unchanged.
- On push: entry {mem_data, fetch_pc} written at wr pointer; fetch_pc <= fetch_pc + 4 (mod 2^tamanho, wraps 0xFFFFFFFC -> 0x00000000).
- On pop: rd pointer advances; count decrements unless push same cycle.
- Pointers wrap modulo profundidade.
- instr_valid = (count != 0); instr/instr_pc come from the head entry (registered storage, no combinational path from mem_data). 0 when empty.
- Latency: first instruction valid 1 cycle after reset deassertion edge; steady state 1 instruction/cycle when instr_ready held high.
- redirect (highest priority): at the edge, count<=0, pointers<=0, fetch_pc<={redirect_pc[tamanho-1:2],2'b00}; no push, no pop that cycle (head presented that cycle is discarded even if instr_ready=1). Target instruction valid 1 cycle after redirect edge (unless halt).
- redirect while halt: flush and PC load still happen; fetching resumes when halt drops.
- Back-to-back redirects: each one reloads; last wins.
- halt: no pushes, fetch_pc frozen; pops continue until empty.
- instr_ready while empty: ignored.
- Reset mid-operation: all state returns to reset values immediately, pending entries lost.

Test Plan:
- Memory word i = 0x1000_0000+i; release reset, instr_ready=1 -> instr_valid rises after 1st edge; successive instr/instr_pc = 0x10000000/0x0, 0x10000001/0x4, 0x10000002/0x8, one per cycle.
- instr_ready=0 for 8 cycles -> count saturates at 4, fetch_pc stops at 0x10, head stays 0x10000000/0x0; then instr_ready=1 -> entries 0..7 delivered in order, no gaps or duplicates.
- Full FIFO with instr_ready=1 pulse of 1 cycle -> pop+push same edge, count stays 4, fetch_pc advances to 0x14.
- redirect=1, redirect_pc=0x43 with 3 entries queued -> next cycle count=0, instr_valid=0, mem_addr=0x40; following cycle instr=0x10000010, instr_pc=0x40.
- halt=1 with 4 entries, instr_ready=1 -> 4 entries drain, instr_valid falls, mem_addr constant; halt=0 -> fetch resumes at held PC.
- pc_inicial=0xFFFFFFF8 -> instr_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; assert rst_n low mid-stream -> instr_valid=0, count=0 immediately, asynchronously.
